// File: rtl/bpm_converter.sv
// Heart-rate converter: RR interval in ticks -> rounded, clamped beats per minute.
// A radix-2 restoring divider produces one quotient bit per clock.
module bpm_converter #(
  parameter int SAMPLE_RATE = 250,
  parameter int MIN_BPM     = 30,
  parameter int MAX_BPM     = 220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] avg_interval,
  input  logic        interval_valid,
  output logic [15:0] bpm,
  output logic        bpm_valid,
  output logic        busy,
  output logic        err_range
);

  localparam logic [31:0] TICKS_PER_MIN = 32'(60 * SAMPLE_RATE);
  localparam logic [31:0] MIN_Q = 32'(MIN_BPM);
  localparam logic [31:0] MAX_Q = 32'(MAX_BPM);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state;
  logic        iv_q;
  logic [31:0] divisor;
  logic [31:0] dividend;
  logic [32:0] rem;
  logic [31:0] quot;
  logic [4:0]  cnt;

  logic        start;
  logic [33:0] rem_sh;
  logic [32:0] rem_sub;
  logic        q_bit;

  assign start   = interval_valid & ~iv_q;
  assign rem_sh  = {rem, dividend[cnt]};
  assign q_bit   = rem_sh >= {2'b00, divisor};
  assign rem_sub = rem_sh[32:0] - {1'b0, divisor};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      iv_q      <= 1'b0;
      divisor   <= '0;
      dividend  <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      busy      <= 1'b0;
      err_range <= 1'b0;
    end else begin
      iv_q      <= interval_valid;
      bpm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (avg_interval == '0) begin
              bpm       <= '0;
              err_range <= 1'b1;
              bpm_valid <= 1'b1;
            end else begin
              // Adding half the divisor rounds the quotient to nearest.
              divisor  <= avg_interval;
              dividend <= TICKS_PER_MIN + (avg_interval >> 1);
              rem      <= '0;
              quot     <= '0;
              cnt      <= 5'd31;
              busy     <= 1'b1;
              state    <= DIV;
            end
          end
        end
        DIV: begin
          rem  <= q_bit ? rem_sub : rem_sh[32:0];
          quot <= {quot[30:0], q_bit};
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0)
            state <= DONE;
        end
        DONE: begin
          if (quot < MIN_Q) begin
            bpm       <= MIN_Q[15:0];
            err_range <= 1'b1;
          end else if (quot > MAX_Q) begin
            bpm       <= MAX_Q[15:0];
            err_range <= 1'b1;
          end else begin
            bpm       <= quot[15:0];
            err_range <= 1'b0;
          end
          bpm_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpm_converter.sv
// Directed bench for bpm_converter: latency, rounding, clamping,
// zero divisor, start edge detection and mid-conversion reset.
module tb_bpm_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avg_interval;
  logic        interval_valid;
  logic [15:0] bpm;
  logic        bpm_valid;
  logic        busy;
  logic        err_range;

  int n_checks = 0;
  int n_fail   = 0;

  bpm_converter #(
    .SAMPLE_RATE(250),
    .MIN_BPM(30),
    .MAX_BPM(220)
  ) dut (
    .clk(clk),
    .rst(rst),
    .avg_interval(avg_interval),
    .interval_valid(interval_valid),
    .bpm(bpm),
    .bpm_valid(bpm_valid),
    .busy(busy),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Raise valid, then observe 40 cycles; returns latency (cycles from the
  // start edge to the negedge where bpm_valid is seen), busy cycles, pulses.
  task automatic do_conv(input logic [31:0] avg, output int lat,
                         output int bcnt, output int vcnt);
    lat = 0; bcnt = 0; vcnt = 0;
    @(negedge clk);
    avg_interval   = avg;
    interval_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (bpm_valid) begin
        vcnt++;
        if (lat == 0) lat = i;
      end
    end
    interval_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    interval_valid = 1'b0;
    avg_interval = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bpm !== 16'd0) begin
      n_fail++; $display("FAIL reset_bpm got %0d want 0", bpm);
    end
    n_checks++;
    if (bpm_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", bpm_valid);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (err_range !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b want 0", err_range);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    logic [31:0] avgs [3] = '{32'd250, 32'd150, 32'd200};
    logic [15:0] exps [3] = '{16'd60, 16'd100, 16'd75};
    int lat, bcnt, vcnt;
    for (int t = 0; t < 3; t++) begin
      do_conv(avgs[t], lat, bcnt, vcnt);
      n_checks++;
      if (bpm !== exps[t]) begin
        n_fail++; $display("FAIL nom_bpm avg=%0d got %0d want %0d", avgs[t], bpm, exps[t]);
      end
      n_checks++;
      if (err_range !== 1'b0) begin
        n_fail++; $display("FAIL nom_err avg=%0d got %b want 0", avgs[t], err_range);
      end
      n_checks++;
      if (lat !== 34) begin
        n_fail++; $display("FAIL nom_latency avg=%0d got %0d want 34", avgs[t], lat);
      end
      n_checks++;
      if (bcnt !== 33) begin
        n_fail++; $display("FAIL nom_busy avg=%0d got %0d want 33", avgs[t], bcnt);
      end
      n_checks++;
      if (vcnt !== 1) begin
        n_fail++; $display("FAIL nom_pulses avg=%0d got %0d want 1", avgs[t], vcnt);
      end
    end
  endtask

  task automatic test_clamp;
    logic [31:0] avgs [3] = '{32'd50, 32'd1000, 32'hFFFF_FFFF};
    logic [15:0] exps [3] = '{16'd220, 16'd30, 16'd30};
    int lat, bcnt, vcnt;
    for (int t = 0; t < 3; t++) begin
      do_conv(avgs[t], lat, bcnt, vcnt);
      n_checks++;
      if (bpm !== exps[t]) begin
        n_fail++; $display("FAIL clamp_bpm avg=%0h got %0d want %0d", avgs[t], bpm, exps[t]);
      end
      n_checks++;
      if (err_range !== 1'b1) begin
        n_fail++; $display("FAIL clamp_err avg=%0h got %b want 1", avgs[t], err_range);
      end
      n_checks++;
      if (vcnt !== 1) begin
        n_fail++; $display("FAIL clamp_pulses avg=%0h got %0d want 1", avgs[t], vcnt);
      end
    end
  endtask

  task automatic test_zero;
    int lat, bcnt, vcnt;
    do_conv(32'd0, lat, bcnt, vcnt);
    n_checks++;
    if (bpm !== 16'd0) begin
      n_fail++; $display("FAIL zero_bpm got %0d want 0", bpm);
    end
    n_checks++;
    if (err_range !== 1'b1) begin
      n_fail++; $display("FAIL zero_err got %b want 1", err_range);
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++; $display("FAIL zero_latency got %0d want 1", lat);
    end
    n_checks++;
    if (bcnt !== 0) begin
      n_fail++; $display("FAIL zero_busy got %0d want 0", bcnt);
    end
    n_checks++;
    if (vcnt !== 1) begin
      n_fail++; $display("FAIL zero_pulses got %0d want 1", vcnt);
    end
  endtask

  task automatic test_hold;
    int vcnt = 0;
    @(negedge clk);
    avg_interval   = 32'd150;
    interval_valid = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bpm_valid) vcnt++;
    end
    interval_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vcnt !== 1) begin
      n_fail++; $display("FAIL hold_pulses got %0d want 1", vcnt);
    end
    n_checks++;
    if (bpm !== 16'd100) begin
      n_fail++; $display("FAIL hold_bpm got %0d want 100", bpm);
    end
  endtask

  task automatic test_toggle_busy;
    int vcnt = 0;
    int lat, bcnt, v2;
    @(negedge clk);
    avg_interval   = 32'd250;
    interval_valid = 1'b1;
    repeat (5) @(negedge clk);
    interval_valid = 1'b0;
    @(negedge clk);
    avg_interval   = 32'd50;
    interval_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bpm_valid) vcnt++;
    end
    interval_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (vcnt !== 1) begin
      n_fail++; $display("FAIL toggle_pulses got %0d want 1", vcnt);
    end
    n_checks++;
    if (bpm !== 16'd60 || err_range !== 1'b0) begin
      n_fail++; $display("FAIL toggle_bpm got %0d/%b want 60/0", bpm, err_range);
    end
    do_conv(32'd200, lat, bcnt, v2);
    n_checks++;
    if (bpm !== 16'd75 || v2 !== 1) begin
      n_fail++; $display("FAIL toggle_second got %0d/%0d want 75/1", bpm, v2);
    end
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    @(negedge clk);
    avg_interval   = 32'd150;
    interval_valid = 1'b1;
    for (int i = 0; i < 40 && !bpm_valid; i++) @(negedge clk);
    // bpm_valid seen: the FSM is back in IDLE; re-arm at once
    interval_valid = 1'b0;
    @(negedge clk);
    avg_interval   = 32'd250;
    interval_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bpm_valid && lat == 0) lat = i;
    end
    interval_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL b2b_latency got %0d want 34", lat);
    end
    n_checks++;
    if (bpm !== 16'd60) begin
      n_fail++; $display("FAIL b2b_bpm got %0d want 60", bpm);
    end
  endtask

  task automatic test_reset_mid;
    int vcnt = 0;
    int lat, bcnt, v2;
    @(negedge clk);
    avg_interval   = 32'd150;
    interval_valid = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bpm !== 16'd0 || busy !== 1'b0 || err_range !== 1'b0 || bpm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got bpm=%0d busy=%b err=%b v=%b want all 0",
               bpm, busy, err_range, bpm_valid);
    end
    interval_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bpm_valid || busy) vcnt++;
    end
    n_checks++;
    if (vcnt !== 0) begin
      n_fail++; $display("FAIL mid_reset_activity got %0d want 0", vcnt);
    end
    do_conv(32'd250, lat, bcnt, v2);
    n_checks++;
    if (bpm !== 16'd60 || err_range !== 1'b0 || lat !== 34) begin
      n_fail++;
      $display("FAIL mid_reset_restart got %0d/%b lat %0d want 60/0 lat 34", bpm, err_range, lat);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_zero();
    test_hold();
    test_toggle_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
